// File: rtl/mem_bilo_db_rd.sv
// mem_bilo_db_rd: read sequencer for the block-in/line-out deblocking buffer.
// Walks one region in raster line order, issues buffer reads, absorbs the
// 1-cycle read latency and streams 32-pixel lines out through a 2-entry
// FIFO with valid/ready backpressure.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module mem_bilo_db_rd (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [1:0]                    sel_i,
    output logic                          ren_o,
    output logic [7:0]                    raddr_o,
    input  logic [`PIXEL_WIDTH*32-1:0]    rdata_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [`PIXEL_WIDTH*32-1:0]    data_o,
    output logic [6:0]                    line_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int DW = `PIXEL_WIDTH * 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [6:0]      k_q, k_d;
    logic            inflight_q, inflight_d;
    logic [6:0]      inflight_line_q, inflight_line_d;
    logic [1:0]      count_q, count_d;
    logic [DW-1:0]   fifo_data_q [2];
    logic [DW-1:0]   fifo_data_d [2];
    logic [6:0]      fifo_line_q [2];
    logic [6:0]      fifo_line_d [2];
    logic            done_q, done_d;

    logic [6:0]      last_k;
    logic [7:0]      addr;
    logic [2:0]      occ;
    logic            pop;
    logic            ren;
    logic            pop_fifo;
    logic            wr_sel;

    // Region geometry: beat count minus one and the buffer address of beat k.
    // Top rows live at 0xC0: bit 3 selects the half, bit 2 selects luma/chroma.
    always_comb begin
        last_k = 7'd7;
        addr   = 8'h00;
        case (sel_q)
            2'd0: begin
                last_k = 7'd127;
                addr   = {1'b0, k_q[6], k_q[0], k_q[5:3], k_q[2:1]};
            end
            2'd1: begin
                last_k = 7'd63;
                addr   = {2'b10, k_q[5:3], k_q[0], k_q[2:1]};
            end
            2'd2: begin
                last_k = 7'd7;
                addr   = {4'b1100, k_q[0], 1'b0, k_q[2:1]};
            end
            default: begin
                last_k = 7'd7;
                addr   = {4'b1100, k_q[0], 1'b1, k_q[2:1]};
            end
        endcase
    end

    // Output stream: FIFO head when stored, otherwise bypass the read data
    // that is arriving this cycle so an empty FIFO costs no latency.
    always_comb begin
        valid_o = (count_q != 2'd0) || inflight_q;
        data_o  = '0;
        line_o  = '0;
        if (count_q != 2'd0) begin
            data_o = fifo_data_q[0];
            line_o = fifo_line_q[0];
        end else if (inflight_q) begin
            data_o = rdata_i;
            line_o = inflight_line_q;
        end
        pop = valid_o & ready_i;
    end

    // Credit check: stored + in flight - leaving must leave room for one more.
    always_comb begin
        occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        ren     = (state_q == ST_RUN) && (occ < 3'd2);
        ren_o   = ren;
        raddr_o = ren ? addr : 8'h00;
        busy_o  = (state_q != ST_IDLE);
        done_o  = done_q;
    end

    // FIFO update: shift on a pop from storage, then write arriving data
    // into the first free slot unless it was consumed via the bypass.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_line_d = fifo_line_q;
        pop_fifo    = pop && (count_q != 2'd0);
        wr_sel      = pop_fifo ? count_q[1] : count_q[0];
        if (pop_fifo) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_line_d[0] = fifo_line_q[1];
        end
        if (inflight_q && !(count_q == 2'd0 && pop)) begin
            fifo_data_d[wr_sel] = rdata_i;
            fifo_line_d[wr_sel] = inflight_line_q;
        end
        count_d         = count_q + {1'b0, inflight_q} - {1'b0, pop};
        inflight_d      = ren;
        inflight_line_d = ren ? k_q : inflight_line_q;
    end

    // Sequencer: accept start, issue N reads, wait for the last beat to leave.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q high means the previous run is finishing this cycle
                if (start_i && !done_q) begin
                    state_d = ST_RUN;
                    sel_d   = sel_i;
                    k_d     = 7'd0;
                end
            end
            ST_RUN: begin
                if (ren) begin
                    k_d = k_q + 7'd1;
                    if (k_q == last_k) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && (line_o == last_k)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any run and drops in-flight data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sel_q           <= 2'd0;
            k_q             <= 7'd0;
            inflight_q      <= 1'b0;
            inflight_line_q <= 7'd0;
            count_q         <= 2'd0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            k_q             <= k_d;
            inflight_q      <= inflight_d;
            inflight_line_q <= inflight_line_d;
            count_q         <= count_d;
            done_q          <= done_d;
        end
    end

    // FIFO storage slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_line_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_line_q[i] <= fifo_line_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_bilo_db_rd.sv
// Testbench for mem_bilo_db_rd: buffer model returns data equal to the
// address; expected addresses/lines/data are queued at start and compared
// as reads issue and beats pop.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_mem_bilo_db_rd;

    localparam int DW = `PIXEL_WIDTH * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    sel_i = 2'd0;
    logic          ren_o;
    logic [7:0]    raddr_o;
    logic [DW-1:0] rdata_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [DW-1:0] data_o;
    logic [6:0]    line_o;
    logic          busy_o;
    logic          done_o;

    mem_bilo_db_rd dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .sel_i   (sel_i),
        .ren_o   (ren_o),
        .raddr_o (raddr_o),
        .rdata_i (rdata_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .line_o  (line_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt, pop_cnt, done_cnt, out_cnt;
    int first_ren, first_valid, last_valid, done_cyc;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [6:0]    prev_line;
    logic [7:0]    exp_addr_q[$];
    logic [6:0]    exp_line_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [7:0]    obs_addr[$];
    logic          bus_ren = 1'b0;
    logic [7:0]    bus_addr = 8'h00;

    function automatic logic [DW-1:0] mk_data(input logic [7:0] a);
        logic [DW-1:0] d;
        for (int p = 0; p < 32; p++) d[p*`PIXEL_WIDTH +: `PIXEL_WIDTH] = `PIXEL_WIDTH'(a);
        return d;
    endfunction

    function automatic logic [7:0] exp_addr(input logic [1:0] sel, input int k);
        int r, h, l;
        h = k % 2;
        r = k / 2;
        l = r % 4;
        case (sel)
            2'd0:    return 8'((r / 32) * 64 + h * 32 + ((r / 4) % 8) * 4 + l);
            2'd1:    return 8'(128 + ((r / 4) % 8) * 8 + h * 4 + l);
            2'd2:    return 8'(192 + h * 8 + l);
            default: return 8'(192 + h * 8 + 4 + l);
        endcase
    endfunction

    // Buffer read port model with one cycle of latency.
    always @(negedge clk) begin
        bus_ren  <= ren_o;
        bus_addr <= raddr_o;
    end
    always @(posedge clk) begin
        if (bus_ren) rdata_i <= mk_data(bus_addr);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe at the negedge, advance past the posedge.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = valid_o && ready_i;
        if (ren_o) begin
            ren_cnt++;
            if (first_ren < 0) first_ren = cyc;
            obs_addr.push_back(raddr_o);
            if (exp_addr_q.size() == 0) chk("ren_extra", DW'(ren_o), '0);
            else chk("raddr", DW'(raddr_o), DW'(exp_addr_q.pop_front()));
        end
        if (valid_o && first_valid < 0) first_valid = cyc;
        if (pop) begin
            pop_cnt++;
            last_valid = cyc;
            if (exp_line_q.size() == 0) chk("pop_extra", DW'(pop), '0);
            else begin
                chk("line", DW'(line_o), DW'(exp_line_q.pop_front()));
                chk("data", data_o, exp_data_q.pop_front());
            end
        end
        if (prev_stall) begin
            chk("hold_valid", DW'(valid_o), DW'(1));
            chk("hold_data", data_o, prev_data);
            chk("hold_line", DW'(line_o), DW'(prev_line));
        end
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        prev_line  = line_o;
        out_cnt = out_cnt + int'(ren_o) - int'(pop);
        chk("outstanding_over2", DW'(out_cnt > 2), '0);
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: ready=1, 1: ready 1,0,0,1 pattern, 2: ready=0 for 20 cycles,
    // 3: ready=1 and reset after 40 beats. spur: extra start pulses.
    task automatic run_region(input logic [1:0] sel, input int mode, input bit spur);
        int n, t, ph;
        logic [7:0] a;
        n = (sel == 2'd0) ? 128 : (sel == 2'd1) ? 64 : 8;
        ren_cnt = 0; pop_cnt = 0; done_cnt = 0;
        first_ren = -1; first_valid = -1; last_valid = -1; done_cyc = -1;
        obs_addr.delete();
        for (int k = 0; k < n; k++) begin
            a = exp_addr(sel, k);
            exp_addr_q.push_back(a);
            exp_line_q.push_back(7'(k));
            exp_data_q.push_back(mk_data(a));
        end
        t = cyc;
        start_i = 1'b1;
        sel_i   = sel;
        ready_i = (mode != 2);
        tick();
        start_i = 1'b0;
        sel_i   = ~sel;
        while (done_cnt == 0 && cyc < t + 1000) begin
            ph = cyc - t;
            case (mode)
                1:       ready_i = (ph % 4 == 0) || (ph % 4 == 3);
                2:       ready_i = (ph > 20);
                default: ready_i = 1'b1;
            endcase
            if (mode == 2 && ph == 21) chk("stall_ren_count", DW'(ren_cnt), DW'(2));
            if (spur) start_i = (ph == 3) || (ph == n + 2);
            if (mode == 3 && pop_cnt == 40) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_ren", DW'(ren_o), '0);
                chk("rst_raddr", DW'(raddr_o), '0);
                chk("rst_valid", DW'(valid_o), '0);
                chk("rst_data", data_o, '0);
                chk("rst_line", DW'(line_o), '0);
                chk("rst_busy", DW'(busy_o), '0);
                chk("rst_done", DW'(done_o), '0);
                exp_addr_q.delete();
                exp_line_q.delete();
                exp_data_q.delete();
                out_cnt = 0;
                prev_stall = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                repeat (4) tick();
                chk("abort_no_done", DW'(done_cnt), '0);
                return;
            end
            tick();
        end
        start_i = 1'b0;
        chk("done_count", DW'(done_cnt), DW'(1));
        chk("beats", DW'(pop_cnt), DW'(n));
        chk("ren_total", DW'(ren_cnt), DW'(n));
        chk("sb_empty", DW'(exp_line_q.size() + exp_addr_q.size()), '0);
        if (mode == 0) begin
            chk("first_ren_cyc", DW'(first_ren - t), DW'(1));
            chk("first_valid_cyc", DW'(first_valid - t), DW'(2));
            chk("last_valid_cyc", DW'(last_valid - t), DW'(n + 1));
            chk("done_cyc", DW'(done_cyc - t), DW'(n + 2));
        end
        if (spur) begin
            repeat (3) begin
                tick();
                chk("idle_after_done_busy", DW'(busy_o), '0);
            end
            chk("single_done", DW'(done_cnt), DW'(1));
        end
    endtask

    logic [7:0] luma_ref [9] = '{8'h00, 8'h20, 8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23, 8'h04};
    logic [7:0] tch_ref  [8] = '{8'hC4, 8'hCC, 8'hC5, 8'hCD, 8'hC6, 8'hCE, 8'hC7, 8'hCF};

    initial begin
        out_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ren", DW'(ren_o), '0);
        chk("reset_raddr", DW'(raddr_o), '0);
        chk("reset_valid", DW'(valid_o), '0);
        chk("reset_data", data_o, '0);
        chk("reset_line", DW'(line_o), '0);
        chk("reset_busy", DW'(busy_o), '0);
        chk("reset_done", DW'(done_o), '0);
        rst_n = 1'b1;
        tick();
        tick();

        run_region(2'd0, 0, 1'b0);
        for (int i = 0; i < 9; i++) chk("luma_seq", DW'(obs_addr[i]), DW'(luma_ref[i]));
        chk("luma_beat64", DW'(obs_addr[64]), DW'(8'h40));

        run_region(2'd3, 0, 1'b1);
        for (int i = 0; i < 8; i++) chk("topchroma_seq", DW'(obs_addr[i]), DW'(tch_ref[i]));

        run_region(2'd1, 1, 1'b0);
        run_region(2'd2, 2, 1'b0);
        run_region(2'd0, 3, 1'b0);

        run_region(2'd2, 0, 1'b0);
        chk("after_abort_first_addr", DW'(obs_addr[0]), DW'(8'hC0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
